// File: rtl/race_pkg.sv
// -----------------------------------------------------------------------------
// race_pkg
//   Shared constants and types for the race drawing datapath.
//   - Frame geometry (160x120), road column range, car sprite size.
//   - 3-bit colour constants.
//   - Move encoding used by the car position logic, plus the drawing mode
//     selected from the FSM's one-hot strobes.
//   - decode_move: folds the left/right/straight pulses into one move.
// -----------------------------------------------------------------------------
package race_pkg;

    localparam int SCREEN_W   = 160;
    localparam int SCREEN_H   = 120;
    localparam int ROAD_X_MIN = 30;
    localparam int ROAD_X_MAX = 129;
    localparam int CAR_W      = 5;
    localparam int CAR_H      = 12;

    localparam logic [2:0] GREEN = 3'b010;
    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] RED   = 3'b100;

    typedef enum logic [1:0] {
        MV_NONE,
        MV_STRAIGHT,
        MV_LEFT,
        MV_RIGHT
    } move_t;

    typedef enum logic [2:0] {
        MODE_NONE,
        MODE_GREEN_LEFT,
        MODE_BLACK,
        MODE_GREEN_RIGHT,
        MODE_CAR
    } mode_t;

    // Contradictory left+right in one cycle is treated as "go straight".
    function automatic move_t decode_move(input logic left,
                                          input logic right,
                                          input logic straight);
        move_t mv;
        mv = MV_NONE;
        if (left && right) begin
            mv = MV_STRAIGHT;
        end else if (left) begin
            mv = MV_LEFT;
        end else if (right) begin
            mv = MV_RIGHT;
        end else if (straight) begin
            mv = MV_STRAIGHT;
        end
        return mv;
    endfunction

endpackage

// File: rtl/pixel_counter.sv
// -----------------------------------------------------------------------------
// pixel_counter
//   Column/row scan counters for a drawing pass.
//   Ports:
//     clock, reset      : clock and synchronous active-high reset
//     enable            : a drawing mode is active this cycle
//     inc               : end of row (clear column, advance row)
//     done              : end of pass (clear both); wins over everything
//     counterx/countery : current column / row
//   Both counters wrap at 2**WIDTH; the row counter is allowed to step past
//   the last visible row so the caller can detect the end of a pass.
// -----------------------------------------------------------------------------
module pixel_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             inc,
    input  logic             done,
    output logic [WIDTH-1:0] counterx,
    output logic [WIDTH-1:0] countery
);

    logic [WIDTH-1:0] counterx_reg;
    logic [WIDTH-1:0] countery_reg;
    logic [WIDTH-1:0] counterx_next;
    logic [WIDTH-1:0] countery_next;

    always_comb begin
        counterx_next = counterx_reg;
        countery_next = countery_reg;
        if (done) begin
            counterx_next = '0;
            countery_next = '0;
        end else if (enable) begin
            if (inc) begin
                counterx_next = '0;
                countery_next = countery_reg + 1'b1;
            end else begin
                counterx_next = counterx_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            counterx_reg <= '0;
            countery_reg <= '0;
        end else begin
            counterx_reg <= counterx_next;
            countery_reg <= countery_next;
        end
    end

    assign counterx = counterx_reg;
    assign countery = countery_reg;

endmodule

// File: rtl/race_datapath.sv
// -----------------------------------------------------------------------------
// race_datapath
//   Datapath stage behind the race control FSM. Scans pixel counters for the
//   FSM, turns the one-hot drawing strobes into registered VGA writes on a
//   160x120 3-bit-colour frame, and keeps the car column, applying buffered
//   left/right moves with clamping to the road.
//
//   Ports:
//     clock, reset           : clock, synchronous active-high reset
//     draw_bg_green_left     : paint left verge   (lowest priority)
//     draw_bg_black, erase   : paint road black
//     draw_bg_green_right    : paint right verge
//     draw_car, update_car   : paint car sprite   (highest priority)
//     inc, done              : row end / pass end for the counters
//     plot_in                : FSM write request
//     left, right, straight  : one-cycle move pulses
//     counterx, countery     : scan counters back to the FSM
//     vga_x, vga_y, colour   : registered pixel address / colour
//     plot                   : registered VGA write enable
//     wall_hit               : (RACE_WALL_HIT_EN only) one-cycle pulse after a
//                              move that had to be clamped
//
//   Optional feature macro: RACE_WALL_HIT_EN
// -----------------------------------------------------------------------------
module race_datapath
    import race_pkg::*;
#(
    parameter int         CAR_X_INIT = 78,
    parameter int         CAR_Y_INIT = 100,
    parameter int         STEP       = 5,
    parameter logic [2:0] CAR_COLOUR = 3'b100
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       draw_bg_green_left,
    input  logic       draw_bg_black,
    input  logic       draw_bg_green_right,
    input  logic       draw_car,
    input  logic       update_car,
    input  logic       erase,
    input  logic       inc,
    input  logic       done,
    input  logic       plot_in,
    input  logic       left,
    input  logic       right,
    input  logic       straight,
    output logic [7:0] counterx,
    output logic [7:0] countery,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] colour,
    output logic       plot
`ifdef RACE_WALL_HIT_EN
    ,
    output logic       wall_hit
`endif
);

    // All address arithmetic is done in 9 bits so sums past 255 are seen
    // as out of frame instead of wrapping back into it.
    localparam logic [8:0] GREEN_LEFT_MAX9  = 9'(ROAD_X_MIN - 1);
    localparam logic [8:0] ROAD_MIN_X9      = 9'(ROAD_X_MIN);
    localparam logic [8:0] ROAD_MAX_X9      = 9'(ROAD_X_MAX);
    localparam logic [8:0] GREEN_RIGHT_MIN9 = 9'(ROAD_X_MAX + 1);
    localparam logic [8:0] SCREEN_MAX_X9    = 9'(SCREEN_W - 1);
    localparam logic [8:0] SCREEN_MAX_Y9    = 9'(SCREEN_H - 1);
    localparam logic [8:0] CAR_MAX_COL9     = 9'(CAR_W - 1);
    localparam logic [8:0] CAR_MAX_ROW9     = 9'(CAR_H - 1);
    localparam logic [8:0] CAR_Y9           = 9'(CAR_Y_INIT);

    // Car left column may range so the whole sprite stays on the road.
    localparam logic [7:0] CAR_X_MIN  = 8'(ROAD_X_MIN);
    localparam logic [7:0] CAR_X_MAX  = 8'(ROAD_X_MAX - CAR_W + 1);
    localparam logic [8:0] CAR_X_MIN9 = 9'(ROAD_X_MIN);
    localparam logic [8:0] CAR_X_MAX9 = 9'(ROAD_X_MAX - CAR_W + 1);
    localparam logic [7:0] STEP8      = 8'(STEP);
    localparam logic [8:0] STEP9      = 9'(STEP);

    // ------------------------------------------------------------------
    // Mode select
    // ------------------------------------------------------------------
    mode_t mode;
    logic  mode_active;
    logic  car_busy;

    assign car_busy = draw_car || update_car;

    always_comb begin
        mode = MODE_NONE;
        if (car_busy) begin
            mode = MODE_CAR;
        end else if (erase || draw_bg_black) begin
            mode = MODE_BLACK;
        end else if (draw_bg_green_right) begin
            mode = MODE_GREEN_RIGHT;
        end else if (draw_bg_green_left) begin
            mode = MODE_GREEN_LEFT;
        end
    end

    assign mode_active = (mode != MODE_NONE);

    // ------------------------------------------------------------------
    // Scan counters
    // ------------------------------------------------------------------
    pixel_counter #(
        .WIDTH(8)
    ) u_pixel_counter (
        .clock    (clock),
        .reset    (reset),
        .enable   (mode_active),
        .inc      (inc),
        .done     (done),
        .counterx (counterx),
        .countery (countery)
    );

    // ------------------------------------------------------------------
    // Pixel address / colour from the current counters
    // ------------------------------------------------------------------
    logic [7:0] car_x_reg;
    logic [7:0] car_x_next;
    logic [8:0] counterx9;
    logic [8:0] countery9;
    logic [8:0] pix_x;
    logic [8:0] pix_y;
    logic [2:0] pix_colour;
    logic       pix_valid;
    logic       row_in_frame;

    assign counterx9    = {1'b0, counterx};
    assign countery9    = {1'b0, countery};

    always_comb begin
        pix_x        = counterx9;
        pix_y        = countery9;
        pix_colour   = BLACK;
        pix_valid    = 1'b0;
        row_in_frame = (pix_y <= SCREEN_MAX_Y9);
        case (mode)
            MODE_CAR: begin
                pix_x      = {1'b0, car_x_reg} + counterx9;
                pix_y      = CAR_Y9 + countery9;
                pix_colour = CAR_COLOUR;
                // The sprite is clipped by the counters, not by the frame.
                pix_valid  = (counterx9 <= CAR_MAX_COL9) && (countery9 <= CAR_MAX_ROW9);
            end
            MODE_BLACK: begin
                pix_x      = ROAD_MIN_X9 + counterx9;
                pix_colour = BLACK;
                pix_valid  = (pix_x >= ROAD_MIN_X9) && (pix_x <= ROAD_MAX_X9) && row_in_frame;
            end
            MODE_GREEN_RIGHT: begin
                pix_colour = GREEN;
                pix_valid  = (pix_x >= GREEN_RIGHT_MIN9) && (pix_x <= SCREEN_MAX_X9) && row_in_frame;
            end
            MODE_GREEN_LEFT: begin
                pix_colour = GREEN;
                pix_valid  = (pix_x <= GREEN_LEFT_MAX9) && row_in_frame;
            end
            default: begin
                pix_valid = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output register (one cycle from strobe/counters to VGA outputs)
    // ------------------------------------------------------------------
    logic [7:0] vga_x_reg;
    logic [6:0] vga_y_reg;
    logic [2:0] colour_reg;
    logic       plot_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            vga_x_reg  <= '0;
            vga_y_reg  <= '0;
            colour_reg <= '0;
            plot_reg   <= 1'b0;
        end else begin
            vga_x_reg  <= pix_x[7:0];
            vga_y_reg  <= pix_y[6:0];
            colour_reg <= pix_colour;
            plot_reg   <= plot_in && mode_active && pix_valid;
        end
    end

    assign vga_x  = vga_x_reg;
    assign vga_y  = vga_y_reg;
    assign colour = colour_reg;
    assign plot   = plot_reg;

    // ------------------------------------------------------------------
    // Car position and pending move
    // ------------------------------------------------------------------
    // A move arriving during a car draw is parked and applied once the draw
    // strobes drop, so a sprite is never drawn with a mid-pass position
    // change. Outside a car draw a fresh pulse is applied immediately.
    move_t      pending_reg;
    move_t      pending_next;
    move_t      new_move;
    move_t      apply_move;
    logic [8:0] car_x9;
    logic       left_clip;
    logic       right_clip;

    assign new_move   = decode_move(left, right, straight);
    assign apply_move = (new_move != MV_NONE) ? new_move : pending_reg;
    assign car_x9     = {1'b0, car_x_reg};
    assign left_clip  = (car_x9 < (CAR_X_MIN9 + STEP9));
    assign right_clip = ((car_x9 + STEP9) > CAR_X_MAX9);

    always_comb begin
        pending_next = pending_reg;
        car_x_next   = car_x_reg;
        if (car_busy) begin
            if (new_move != MV_NONE) begin
                pending_next = new_move;
            end
        end else begin
            pending_next = MV_NONE;
            case (apply_move)
                MV_LEFT:  car_x_next = left_clip  ? CAR_X_MIN : (car_x_reg - STEP8);
                MV_RIGHT: car_x_next = right_clip ? CAR_X_MAX : (car_x_reg + STEP8);
                default:  car_x_next = car_x_reg;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            car_x_reg   <= 8'(CAR_X_INIT);
            pending_reg <= MV_NONE;
        end else begin
            car_x_reg   <= car_x_next;
            pending_reg <= pending_next;
        end
    end

`ifdef RACE_WALL_HIT_EN
    // Flags a move whose unclamped result would have left the road.
    logic wall_hit_reg;
    logic wall_hit_next;

    always_comb begin
        wall_hit_next = 1'b0;
        if (!car_busy) begin
            wall_hit_next = ((apply_move == MV_LEFT)  && left_clip) ||
                            ((apply_move == MV_RIGHT) && right_clip);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wall_hit_reg <= 1'b0;
        end else begin
            wall_hit_reg <= wall_hit_next;
        end
    end

    assign wall_hit = wall_hit_reg;
`endif

endmodule

// File: doc/race_datapath.md
Name: race_datapath

Overview:
- Datapath stage directly downstream of the race control FSM.
- Owns the pixel x/y counters fed back to the FSM, and the car position register.
- Converts the FSM's one-hot drawing strobes into VGA adapter writes (x, y, colour, plot) on a 160x120, 3-bit-colour frame.
- Applies left/right moves to the car with clamping at the road edges.

Parameters:
- CAR_X_INIT, 78: car left-column x after reset.
- CAR_Y_INIT, 100: car top-row y (fixed).
- STEP, 5: pixels moved per left/right command.
- CAR_COLOUR, 3'b100: car pixel colour (red).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- draw_bg_green_left  in  1  paint left verge.
- draw_bg_black  in  1  paint road.
- draw_bg_green_right  in  1  paint right verge.
- draw_car  in  1  paint car at current position.
- update_car  in  1  paint car after a move.
- erase  in  1  repaint road black.
- inc  in  1  end of row: clear counterx, advance countery.
- done  in  1  end of pass: clear both counters.
- plot_in  in  1  FSM plot request.
- left, right, straight  in  1 each  one-cycle move pulses.
- counterx  out  8  column counter to FSM.
- countery  out  8  row counter to FSM.
- vga_x  out  8  pixel x.
- vga_y  out  7  pixel y.
- colour  out  3  pixel colour.
- plot  out  1  VGA write enable.

Behaviour:
- Reset (synchronous): counterx=0, countery=0, vga_x=0, vga_y=0, colour=0, plot=0, car_x=CAR_X_INIT, pending move cleared. Reset mid-pass abandons the pass immediately.
- Active mode: draw_car or update_car (car mode) > erase > draw_bg_black > draw_bg_green_right > draw_bg_green_left. Exactly one mode is active; none if all strobes are low.
- Counters, in priority order:
  - done=1: both counters clear to 0.
  - Else, with a mode active: inc=1 gives counterx<=0, countery<=countery+1 (8-bit wrap, no saturation). inc=0 gives counterx<=counterx+1.
  - No mode active: counters hold.
- Pixel address and colour, computed from current counters:
  - green_left: x=counterx, colour 3'b010, valid when x<=29.
  - black / erase: x=30+counterx (9-bit sum), colour 3'b000, valid when 30<=x<=129.
  - green_right: x=counterx, colour 3'b010, valid when 130<=x<=159.
  - car: x=car_x+counterx, y=CAR_Y_INIT+countery, colour CAR_COLOUR, valid when counterx<=4 and countery<=11.
  - Non-car modes: y=countery, valid only when countery<=119.
- Output register: vga_x, vga_y, colour and plot register the combinational result, so latency is 1 cycle from strobe/counter to outputs.
  - plot = plot_in AND mode active AND valid.
  - Invalid or overflow coordinates give plot=0; vga_x/vga_y/colour still update.
- Moves:
  - A left/right/straight pulse is captured into a one-entry pending register. A newer pulse overwrites an older one.
  - left and right in the same cycle capture straight.
  - The pending move is applied in the first cycle where draw_car and update_car are both low. It is applied in the same cycle it is captured if no car draw is active.
  - left: car_x = max(car_x-STEP, 30). right: car_x = min(car_x+STEP, 125). straight: no change.
  - Pending clears on apply.
- The car position never changes during a car-draw pass. This guarantees a consistent sprite.

Optional Feature:
- Macro: RACE_WALL_HIT_EN.
- Defined: adds output wall_hit (1 bit, reset 0). It pulses high for one cycle, the cycle after applying a left/right move whose unclamped result lay outside 30..125.
- Undefined: port absent; clamping unchanged.

Decomposition:
- Package race_pkg holds:
  - SCREEN_W=160, SCREEN_H=120.
  - ROAD_X_MIN=30, ROAD_X_MAX=129.
  - CAR_W=5, CAR_H=12.
  - Colour constants GREEN, BLACK, RED.
  - Move enum {MV_NONE, MV_STRAIGHT, MV_LEFT, MV_RIGHT}.
- One natural sub-module: pixel_counter (counterx/countery with inc/done/enable), reusable by other drawing stages.

Test Plan:
- Reset, then green_left + plot_in for 31 cycles with inc on counterx==30, for 121 rows:
  - plot high for exactly x 0..29, y 0..119 with colour 010.
  - Counters show 0/121 after the final inc; done clears them to 0/0.
- draw_car from reset for 5 cycles per row x 12 rows: 60 plots at x 78..82, y 100..111, colour 100. The first write appears one cycle after the strobe.
- 20 right pulses: car_x steps 83,88,...,123, then clamps to 125. With RACE_WALL_HIT_EN, wall_hit pulses once at the 123->125 step (unclamped 128), and for each further right pulse.
- right pulse during update_car: car_x unchanged until update_car drops, then +5 on that cycle. The second car draw uses the old x throughout.
- left and right in the same cycle: car_x unchanged. draw_car with erase together: car colour and address win.
- reset asserted mid-erase pass: next cycle counters 0/0, plot 0, car_x=78.
